mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Multi-cycle successor to the single-cycle MIPS decoder: a Moore FSM that sequences each instruction over 3-5 cycles on a shared memory and ALU datapath.
- Same instruction set and ALU-op encoding as the single-cycle core, plus a memory-ready handshake, a memory timeout trap, an illegal-opcode flag and a retired-instruction counter.
- Sits between the instruction register (opcode/func) and the multicycle datapath muxes, register-file and memory strobes.

Parameters:
- ALUOP_W, 4: width of alu_op; codes are zero-extended into it, minimum 4.
- MEM_TIMEOUT, 15: maximum consecutive cycles spent waiting for mem_ready before trapping; range 1..255.
- COUNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction[31:26], taken from the instruction register.
- func  in  6  instruction[5:0].
- mem_ready  in  1  memory has completed the current read or write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by the datapath zero flag and bneq.
- bneq  out  1  inverts the zero qualification (bne).
- iord  out  1  0 = memory address from PC, 1 = from ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction-register load.
- mem_to_reg  out  1  write-back data from MDR.
- reg_write  out  1  register-file write enable.
- reg_dest  out  1  destination select: 1 = rd, 0 = rt.
- jal  out  1  force destination $31 and write-back data PC.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  0 = B, 1 = constant 4, 2 = sign-extended immediate, 3 = immediate << 2.
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = register A (jr).
- alu_op  out  ALUOP_W  0 pass, 1 add, 2 addu, 3 and, 4 or, 5 nor, 6 sltu, 7 slt, 8 sll, 9 srl, 10 sub, 11 subu, 12 sra, 13 lui.
- state  out  4  current state encoding, for debug.
- illegal  out  1  sticky; an undefined opcode or func was decoded.
- mem_fault  out  1  sticky; a memory timeout occurred.
- instr_count  out  COUNT_W  number of retired instructions.

Behaviour:
- Reset (asynchronous): state = FETCH (0); wait counter = 0; instr_count = 0; illegal = 0; mem_fault = 0. While reset is high, every strobe and select output is forced to 0.
- Outputs are a function of the registered state plus mem_ready; there are no other combinational input-to-output paths.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BRANCH 8, JUMP 9, ITEX 10, ITWB 11, TRAP 12.
- FETCH:
  - Asserts mem_read, iord = 0, alu_src_a = 0, alu_src_b = 1, alu_op = add.
  - When mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 0, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a = 0, alu_src_b = 3, alu_op = add (branch target). Next state by opcode:
  - 000000 -> RTEX.
  - lw (100011) / sw (101011) -> MEMADR.
  - beq (000100) / bne (000101) -> BRANCH.
  - j (000010) / jal (000011) -> JUMP.
  - addi, addiu, andi, ori, slti, sltiu, lui -> ITEX.
  - Any other opcode -> set illegal, go to FETCH without counting.
- MEMADR: alu_src_a = 1, alu_src_b = 2, alu_op = add; lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read = 1, iord = 1; on mem_ready -> MEMWB.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dest = 0 -> FETCH.
- MEMWR: mem_write = 1, iord = 1; on mem_ready -> FETCH (counted).
- RTEX: alu_src_a = 1, alu_src_b = 0, alu_op from func using the table above.
  - func 001000 (jr): pc_write = 1, pc_src = 3 -> FETCH (counted).
  - Undefined func: set illegal -> FETCH (not counted).
  - Otherwise -> RTWB.
- RTWB: reg_write = 1, reg_dest = 1 -> FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, alu_op = sub, pc_write_cond = 1, pc_src = 1; bneq = 1 for bne -> FETCH.
- JUMP: pc_write = 1, pc_src = 2. For jal also jal = 1 and reg_write = 1 (writes $31 with the already-incremented PC). -> FETCH.
- ITEX: alu_src_a = 1, alu_src_b = 2. alu_op by opcode: addi 1, addiu 2, andi 3, ori 4, slti 7, sltiu 6, lui 13. -> ITWB.
- ITWB: reg_write = 1, reg_dest = 0 -> FETCH.
- instr_count increments by 1 on every transition into FETCH from MEMWB, MEMWR, RTWB, RTEX (jr only), BRANCH, JUMP or ITWB. It wraps modulo 2^COUNT_W.
- Wait counter (FETCH, MEMRD, MEMWR):
  - Cleared on entry to a waiting state and whenever mem_ready = 1; increments each cycle with mem_ready = 0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: set mem_fault, go to TRAP.
- TRAP: all strobes 0; stays there until reset.
- Simultaneous events: mem_ready in the same cycle the counter reaches MEM_TIMEOUT is treated as success (no trap).
- Reset mid-instruction: aborts immediately; no partial write strobe is issued after reset rises.

Test Plan:
- Reset release with mem_ready tied 1, R-type add (func 100000) -> states 0, 1, 6, 7, 0; alu_op = 1 in RTEX; reg_write = 1 and reg_dest = 1 in RTWB; instr_count = 1.
- lw with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles; mem_read = 1 and iord = 1 throughout; mem_to_reg = 1 in MEMWB; total 8 cycles.
- bne -> BRANCH with pc_write_cond = 1, bneq = 1, alu_op = 10; then jal -> JUMP with jal = 1, reg_write = 1, pc_src = 2; instr_count advances by 2.
- Opcode 111111, then R-type func 111111 -> illegal = 1 and stays set; instr_count unchanged; FSM returns to FETCH both times.
- mem_ready held 0 in FETCH with MEM_TIMEOUT = 15 -> TRAP (12) after the 15th wait cycle; mem_fault = 1; state holds at 12 until reset.
- Assert reset during MEMWR -> mem_write drops immediately; state = 0; counters and flags cleared; COUNT_W = 4 wrap test gives 15 -> 0.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control unit: a Moore FSM that sequences fetch, decode and
// execute over a shared memory/ALU datapath, with a memory timeout trap and a retired count.
module mips_multicycle_control #(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               bneq,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               reg_dest,
  output logic               jal,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [3:0]         state,
  output logic               illegal,
  output logic               mem_fault,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_RTWB  = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ITEX   = 4'd10, S_ITWB  = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW    = 6'b100011, OP_SW   = 6'b101011,
                         OP_BEQ   = 6'b000100, OP_BNE   = 6'b000101, OP_J    = 6'b000010,
                         OP_JAL   = 6'b000011, OP_ADDI  = 6'b001000, OP_ADDIU = 6'b001001,
                         OP_ANDI  = 6'b001100, OP_ORI   = 6'b001101, OP_SLTI = 6'b001010,
                         OP_SLTIU = 6'b001011, OP_LUI   = 6'b001111;
  localparam logic [5:0] FN_JR = 6'b001000;

  localparam logic [3:0] ALU_PASS = 4'd0,  ALU_ADD  = 4'd1,  ALU_ADDU = 4'd2,  ALU_AND = 4'd3,
                         ALU_OR   = 4'd4,  ALU_NOR  = 4'd5,  ALU_SLTU = 4'd6,  ALU_SLT = 4'd7,
                         ALU_SLL  = 4'd8,  ALU_SRL  = 4'd9,  ALU_SUB  = 4'd10, ALU_SUBU = 4'd11,
                         ALU_SRA  = 4'd12, ALU_LUI  = 4'd13;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  // {valid, alu code}; jr is valid with a pass-through ALU code.
  function automatic logic [4:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, ALU_ADD};
      6'b100001: return {1'b1, ALU_ADDU};
      6'b100100: return {1'b1, ALU_AND};
      6'b100101: return {1'b1, ALU_OR};
      6'b100111: return {1'b1, ALU_NOR};
      6'b101011: return {1'b1, ALU_SLTU};
      6'b101010: return {1'b1, ALU_SLT};
      6'b000000: return {1'b1, ALU_SLL};
      6'b000010: return {1'b1, ALU_SRL};
      6'b100010: return {1'b1, ALU_SUB};
      6'b100011: return {1'b1, ALU_SUBU};
      6'b000011: return {1'b1, ALU_SRA};
      FN_JR:     return {1'b1, ALU_PASS};
      default:   return {1'b0, ALU_PASS};
    endcase
  endfunction

  function automatic logic [3:0] itype_alu(input logic [5:0] op);
    case (op)
      OP_ADDI:  return ALU_ADD;
      OP_ADDIU: return ALU_ADDU;
      OP_ANDI:  return ALU_AND;
      OP_ORI:   return ALU_OR;
      OP_SLTI:  return ALU_SLT;
      OP_SLTIU: return ALU_SLTU;
      OP_LUI:   return ALU_LUI;
      default:  return ALU_PASS;
    endcase
  endfunction

  state_e               state_q, state_d;
  logic [7:0]           wait_q, wait_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 illegal_q, illegal_d;
  logic                 fault_q, fault_d;
  logic [5:0]           op_q, func_q;
  logic [4:0]           r_dec;
  logic [3:0]           alu_code;
  logic                 retire;
  logic                 wait_expired;

  // Opcode/func are captured in DECODE so outputs never see the IR inputs directly.
  assign r_dec        = rtype_alu(func_q);
  assign wait_expired = !mem_ready && (wait_q == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      op_q      <= '0;
      func_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
      if (state_q == S_DECODE) begin
        op_q   <= opcode;
        func_q <= func;
      end
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path infers a latch.
    state_d       = state_q;
    wait_d        = '0;
    illegal_d     = illegal_q;
    fault_d       = fault_q;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    bneq          = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dest      = 1'b0;
    jal           = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    pc_src        = 2'd0;
    alu_code      = ALU_PASS;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        alu_code  = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_expired) begin
          fault_d = 1'b1;
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        alu_code  = ALU_ADD;
        case (opcode)
          OP_RTYPE:      state_d = S_RTEX;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J, OP_JAL:  state_d = S_JUMP;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_SLTIU, OP_LUI:
                         state_d = S_ITEX;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_code  = ALU_ADD;
        state_d   = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (wait_expired) begin
          fault_d = 1'b1;
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (wait_expired) begin
          fault_d = 1'b1;
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_RTEX: begin
        alu_src_a = 1'b1;
        alu_code  = r_dec[3:0];
        if (func_q == FN_JR) begin
          pc_write = 1'b1;
          pc_src   = 2'd3;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (!r_dec[4]) begin
          illegal_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_RTWB;
        end
      end
      S_RTWB: begin
        reg_write = 1'b1;
        reg_dest  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_code      = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = 2'd1;
        bneq          = (op_q == OP_BNE);
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_src    = 2'd2;
        jal       = (op_q == OP_JAL);
        reg_write = (op_q == OP_JAL);
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ITEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_code  = itype_alu(op_q);
        state_d   = S_ITWB;
      end
      S_ITWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Reset silences every strobe at once, even between clock edges.
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      bneq          = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      reg_dest      = 1'b0;
      jal           = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      pc_src        = 2'd0;
      alu_code      = ALU_PASS;
    end
  end

  assign count_d     = retire ? count_q + COUNT_W'(1) : count_q;
  assign alu_op      = ALUOP_W'(alu_code);
  assign state       = state_q;
  assign illegal     = illegal_q;
  assign mem_fault   = fault_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: a per-instruction step-list model predicts every cycle's
// outputs from the instruction class and the mem_ready pattern.
module tb_mips_multicycle_control;

  localparam int CW  = 4;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    opcode = '0;
  logic [5:0]    func = '0;
  logic          mem_ready = 1'b0;
  logic          pc_write, pc_write_cond, bneq, iord, mem_read, mem_write, ir_write;
  logic          mem_to_reg, reg_write, reg_dest, jal, alu_src_a;
  logic [1:0]    alu_src_b, pc_src;
  logic [3:0]    alu_op, state;
  logic          illegal, mem_fault;
  logic [CW-1:0] instr_count;

  always #5 clk = ~clk;

  mips_multicycle_control #(.ALUOP_W(4), .MEM_TIMEOUT(TMO), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .bneq(bneq), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dest(reg_dest), .jal(jal),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op),
    .state(state), .illegal(illegal), .mem_fault(mem_fault), .instr_count(instr_count)
  );

  typedef struct packed {
    logic pc_write, pc_write_cond, bneq, iord, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_write, reg_dest, jal, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [3:0] alu_op, st;
  } ctl_t;

  int total = 0;
  int bad = 0;

  int            plan_q[$];
  bit            m_retire, m_bad, m_trap, m_illegal, m_fault;
  int            m_wait;
  logic [CW-1:0] m_count;
  int            seen[$];
  int            ticks;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ALU code of an R-type func; -1 marks an undefined func.
  function automatic int r_alu(input logic [5:0] f);
    case (f)
      6'd32: return 1;  6'd33: return 2;  6'd36: return 3;  6'd37: return 4;
      6'd39: return 5;  6'd43: return 6;  6'd42: return 7;  6'd0:  return 8;
      6'd2:  return 9;  6'd34: return 10; 6'd35: return 11; 6'd3:  return 12;
      6'd8:  return 0;
      default: return -1;
    endcase
  endfunction

  function automatic int i_alu(input logic [5:0] op);
    case (op)
      6'd8: return 1;  6'd9: return 2;  6'd12: return 3; 6'd13: return 4;
      6'd10: return 7; 6'd11: return 6; 6'd15: return 13;
      default: return -1;
    endcase
  endfunction

  function automatic ctl_t exp_out(input int st, input bit rdy);
    ctl_t c;
    int   r;
    c    = '0;
    c.st = st[3:0];
    case (st)
      0:  begin c.mem_read = 1; c.alu_src_b = 1; c.alu_op = 1; c.ir_write = rdy; c.pc_write = rdy; end
      1:  begin c.alu_src_b = 3; c.alu_op = 1; end
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2; c.alu_op = 1; end
      3:  begin c.mem_read = 1; c.iord = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      5:  begin c.mem_write = 1; c.iord = 1; end
      6:  begin
            r = r_alu(func);
            c.alu_src_a = 1;
            c.alu_op = (r < 0) ? 4'd0 : 4'(r);
            if (func == 6'd8) begin c.pc_write = 1; c.pc_src = 3; end
          end
      7:  begin c.reg_write = 1; c.reg_dest = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 10; c.pc_write_cond = 1; c.pc_src = 1; c.bneq = (opcode == 6'd5); end
      9:  begin c.pc_write = 1; c.pc_src = 2; c.jal = (opcode == 6'd3); c.reg_write = (opcode == 6'd3); end
      10: begin c.alu_src_a = 1; c.alu_src_b = 2; c.alu_op = 4'(i_alu(opcode)); end
      11: c.reg_write = 1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic start_instr(input logic [5:0] op, input logic [5:0] f);
    opcode   = op;
    func     = f;
    m_retire = 1;
    m_bad    = 0;
    if (op == 6'd0) begin
      if (f == 6'd8) plan_q = '{0, 1, 6};
      else if (r_alu(f) < 0) begin plan_q = '{0, 1, 6}; m_retire = 0; m_bad = 1; end
      else plan_q = '{0, 1, 6, 7};
    end else if (op == 6'd35) plan_q = '{0, 1, 2, 3, 4};
    else if (op == 6'd43) plan_q = '{0, 1, 2, 5};
    else if (op == 6'd4 || op == 6'd5 || op == 6'd2 || op == 6'd3) plan_q = (op < 6'd4) ? '{0, 1, 9} : '{0, 1, 8};
    else if (i_alu(op) >= 0) plan_q = '{0, 1, 10, 11};
    else begin plan_q = '{0, 1}; m_retire = 0; m_bad = 1; end
  endtask

  ctl_t got_ctl;
  assign got_ctl = {pc_write, pc_write_cond, bneq, iord, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_write, reg_dest, jal, alu_src_a, alu_src_b, pc_src,
                    alu_op, state};

  // Called just after a falling edge; returns at the next falling edge.
  task automatic tick(input bit rdy);
    int   st;
    ctl_t want;
    mem_ready = rdy;
    #1;
    st   = m_trap ? 12 : plan_q[0];
    want = exp_out(st, rdy);
    check($sformatf("ctl st=%0d op=%0d fn=%0d rdy=%0d", st, opcode, func, rdy), 32'(got_ctl), 32'(want));
    check("instr_count", 32'(instr_count), 32'(m_count));
    check("illegal", 32'(illegal), 32'(m_illegal));
    check("mem_fault", 32'(mem_fault), 32'(m_fault));
    seen.push_back(int'(state));
    ticks++;
    if (!m_trap) begin
      if ((st == 0 || st == 3 || st == 5) && !rdy) begin
        if (m_wait + 1 == TMO) begin m_trap = 1; m_fault = 1; end
        else m_wait++;
      end else begin
        m_wait = 0;
        void'(plan_q.pop_front());
        if (plan_q.size() == 0) begin
          if (m_retire) m_count++;
          if (m_bad) m_illegal = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic finish_instr(input int fetch_lows, input int mem_lows, input bit rnd);
    int n;
    int fl;
    int ml;
    bit rdy;
    n  = 0;
    fl = fetch_lows;
    ml = mem_lows;
    while (plan_q.size() > 0 && !m_trap) begin
      n++;
      if (n > 300) begin
        total++; bad++;
        $display("FAIL instr budget: got %0d cycles expected at most 300", n);
        break;
      end
      rdy = 1;
      if (rnd) rdy = ($urandom_range(0, 3) != 0);
      else if (plan_q[0] == 0 && fl > 0) begin rdy = 0; fl--; end
      else if ((plan_q[0] == 3 || plan_q[0] == 5) && ml > 0) begin rdy = 0; ml--; end
      tick(rdy);
    end
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] f, input int fl, input int ml, input bit rnd);
    start_instr(op, f);
    finish_instr(fl, ml, rnd);
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    check("reset ctl", 32'(got_ctl), 32'd0);
    check("reset count", 32'(instr_count), 32'd0);
    check("reset flags", 32'({illegal, mem_fault}), 32'd0);
    plan_q.delete();
    m_trap = 0; m_wait = 0; m_count = '0; m_illegal = 0; m_fault = 0;
    @(negedge clk);
    reset = 0;
  endtask

  int exp_seq[4] = '{0, 1, 6, 7};
  int ops[19]    = '{0, 0, 0, 35, 43, 4, 5, 2, 3, 8, 9, 12, 13, 10, 11, 15, 63, 1, 20};
  int fns[15]    = '{32, 33, 36, 37, 39, 43, 42, 0, 2, 34, 35, 3, 8, 63, 1};

  initial begin
    repeat (2) @(negedge clk);
    do_reset();

    // R-type add, memory always ready
    seen.delete();
    run(6'd0, 6'd32, 0, 0, 0);
    check("add state count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      check($sformatf("add seq[%0d]", i), 32'(seen[i]), 32'(exp_seq[i]));
    check("add retired", 32'(instr_count), 32'd1);

    // lw with three stalled MEMRD cycles
    ticks = 0;
    run(6'd35, 6'd0, 0, 3, 0);
    check("lw cycles", 32'(ticks), 32'd8);
    check("lw retired", 32'(instr_count), 32'd2);

    // bne then jal
    run(6'd5, 6'd0, 0, 0, 0);
    run(6'd3, 6'd0, 0, 0, 0);
    check("bne+jal retired", 32'(instr_count), 32'd4);

    // illegal opcode, then illegal func
    run(6'd63, 6'd0, 0, 0, 0);
    check("illegal op flag", 32'(illegal), 32'd1);
    run(6'd0, 6'd63, 0, 0, 0);
    check("illegal fn flag", 32'(illegal), 32'd1);
    check("illegal no retire", 32'(instr_count), 32'd4);
    check("illegal back to fetch", 32'(state), 32'd0);

    // randomized instruction mix and memory latency
    for (int i = 0; i < 400; i++) begin
      if (m_trap) do_reset();
      run(6'(ops[$urandom_range(0, 18)]), 6'(fns[$urandom_range(0, 14)]), 0, 0, 1);
    end

    // ready arrives on the very cycle the counter would expire
    do_reset();
    start_instr(6'd0, 6'd32);
    repeat (TMO - 1) tick(0);
    tick(1);
    check("late ready state", 32'(state), 32'd1);
    check("late ready fault", 32'(mem_fault), 32'd0);
    finish_instr(0, 0, 0);

    // genuine timeout in FETCH
    start_instr(6'd0, 6'd32);
    repeat (TMO - 1) tick(0);
    check("pre-timeout state", 32'(state), 32'd0);
    tick(0);
    check("trap state", 32'(state), 32'd12);
    check("trap fault", 32'(mem_fault), 32'd1);
    repeat (5) tick(1'($urandom_range(0, 1)));
    check("trap holds", 32'(state), 32'd12);

    // reset in the middle of a store; an illegal instruction first leaves a flag set
    do_reset();
    run(6'd1, 6'd0, 0, 0, 0);
    run(6'd8, 6'd0, 0, 0, 0);
    start_instr(6'd43, 6'd0);
    repeat (3) tick(1);
    mem_ready = 0;
    #1;
    check("memwr state", 32'(state), 32'd5);
    check("memwr strobe", 32'(mem_write), 32'd1);
    reset = 1;
    #1;
    check("abort strobe", 32'(mem_write), 32'd0);
    check("abort state", 32'(state), 32'd0);
    check("abort count", 32'(instr_count), 32'd0);
    check("abort illegal", 32'(illegal), 32'd0);
    plan_q.delete();
    m_trap = 0; m_wait = 0; m_count = '0; m_illegal = 0; m_fault = 0;
    @(negedge clk);
    reset = 0;

    // retired counter wraps at 2^CW
    repeat (15) run(6'd8, 6'd0, 0, 0, 0);
    check("count at 15", 32'(instr_count), 32'd15);
    run(6'd8, 6'd0, 0, 0, 0);
    check("count wraps", 32'(instr_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
